wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_arbiter_if.sv | 49 ++++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter.
// Contents: result width, default FIFO depth and starvation limit, the x0
// register index, and wb_req_t, the payload stored in the channel-B FIFO.
package wb_pkg;

    localparam int unsigned WB_WIDTH       = 32;
    localparam int unsigned RD_W           = 5;
    localparam int unsigned DEPTH_DEF      = 4;
    localparam int unsigned STARVE_LIM_DEF = 8;

    localparam logic [RD_W-1:0] REG_ZERO = 5'd0;

    // One pending register-file write; live=0 means the entry was superseded.
    typedef struct packed {
        logic                live;
        logic [RD_W-1:0]     rd;
        logic [WB_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer / register-file bundle for the writeback arbiter.
// slave  : arbiter side (consumes A/B results, drives WE3/AD3/WD3/busy).
// master : producer/testbench side.
// With WB_BYPASS_EN defined the bundle also carries fwd_valid/fwd_rd/fwd_data.
interface wb_arbiter_if #(
    parameter int unsigned WIDTH = wb_pkg::WB_WIDTH
);
    logic             a_valid;
    logic             a_ready;
    logic [4:0]       a_rd;
    logic [WIDTH-1:0] a_data;

    logic             b_valid;
    logic             b_ready;
    logic [4:0]       b_rd;
    logic [WIDTH-1:0] b_data;

    logic             WE3;
    logic [4:0]       AD3;
    logic [WIDTH-1:0] WD3;
    logic             busy;

`ifdef WB_BYPASS_EN
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [WIDTH-1:0] fwd_data;
`endif

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output WE3, AD3, WD3, busy
`ifdef WB_BYPASS_EN
        , output fwd_valid, fwd_rd, fwd_data
`endif
    );

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  WE3, AD3, WD3, busy
`ifdef WB_BYPASS_EN
        , input fwd_valid, fwd_rd, fwd_data
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// Channel-B holding FIFO of wb_req_t with a register-number kill port.
// Ports: clk, rst (sync, active-high), push_i/push_req_i, pop_i,
//        kill_i/kill_rd_i (clear live on every entry whose rd matches),
//        head_o (entry at read pointer), full_o, empty_o.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  wb_req_t         push_req_i,
    input  logic            pop_i,
    input  logic            kill_i,
    input  logic [RD_W-1:0] kill_rd_i,
    output wb_req_t         head_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Kill runs before push so a same-cycle push is never killed.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[AW'(i)] = mem_q[AW'(i)];
            if (kill_i && (mem_q[AW'(i)].rd == kill_rd_i)) begin
                mem_d[AW'(i)].live = 1'b0;
            end
        end
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_req_i;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[AW'(i)] <= mem_d[AW'(i)];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU result (channel A) and the
// FIFO-buffered long-latency result (channel B) into one registered
// register-file write per cycle on WE3/AD3/WD3.
// Ports: clk, rst (sync, active-high), bus (wb_arbiter_if.slave):
//   a_valid/a_ready/a_rd/a_data, b_valid/b_ready/b_rd/b_data,
//   WE3/AD3/WD3 (registered write), busy (FIFO non-empty or WE3).
// Optional macro WB_BYPASS_EN: adds fwd_valid/fwd_rd/fwd_data, a
// combinational view of the write selected this cycle (WE3 one cycle later).
// WIDTH is expected to equal wb_pkg::WB_WIDTH (FIFO payload width).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH      = WB_WIDTH,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);

    localparam int unsigned     CNT_W   = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

    wb_req_t          head;
    wb_req_t          push_req;
    logic             full, empty;
    logic             a_ready_c, b_ready_c;
    logic             a_fire_c, a_fire_nz_c, push_c, pop_c;
    logic             head_live_c, head_dead_c;
    logic             sel_we_c;
    logic [RD_W-1:0]  sel_rd_c;
    logic [WIDTH-1:0] sel_data_c;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we3_q;
    logic [RD_W-1:0]  ad3_q;
    logic [WIDTH-1:0] wd3_q;

    // A is throttled for exactly the cycle the starve counter sits at its limit.
    assign a_ready_c = (cnt_q != CNT_LIM);
    assign b_ready_c = !full;

    assign push_req = '{live: 1'b1, rd: bus.b_rd, data: WB_WIDTH'(bus.b_data)};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_c),
        .push_req_i (push_req),
        .pop_i      (pop_c),
        .kill_i     (a_fire_nz_c),
        .kill_rd_i  (bus.a_rd),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Per-cycle selection; a dead head (already killed or killed by this A) pops for free.
    always_comb begin
        a_fire_c    = bus.a_valid && a_ready_c;
        a_fire_nz_c = a_fire_c && (bus.a_rd != REG_ZERO);
        push_c      = bus.b_valid && b_ready_c && (bus.b_rd != REG_ZERO);
        head_live_c = !empty && head.live;
        head_dead_c = !empty && (!head.live || (a_fire_nz_c && (head.rd == bus.a_rd)));

        sel_we_c   = 1'b0;
        sel_rd_c   = REG_ZERO;
        sel_data_c = '0;
        if (a_fire_nz_c) begin
            sel_we_c   = 1'b1;
            sel_rd_c   = bus.a_rd;
            sel_data_c = bus.a_data;
        end else if (!a_fire_c && head_live_c) begin
            sel_we_c   = 1'b1;
            sel_rd_c   = head.rd;
            sel_data_c = WIDTH'(head.data);
        end

        pop_c = head_dead_c || (!a_fire_c && head_live_c);

        cnt_d = cnt_q;
        if (pop_c) begin
            cnt_d = '0;
        end else if (head_live_c && a_fire_c && (cnt_q != CNT_LIM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Write port register and starve counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            we3_q <= 1'b0;
            ad3_q <= REG_ZERO;
            wd3_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            we3_q <= sel_we_c;
            if (sel_we_c) begin
                ad3_q <= sel_rd_c;
                wd3_q <= sel_data_c;
            end
        end
    end

    assign bus.a_ready = a_ready_c;
    assign bus.b_ready = b_ready_c;
    assign bus.WE3     = we3_q;
    assign bus.AD3     = ad3_q;
    assign bus.WD3     = wd3_q;
    assign bus.busy    = !empty || we3_q;

`ifdef WB_BYPASS_EN
    assign bus.fwd_valid = sel_we_c;
    assign bus.fwd_rd    = sel_rd_c;
    assign bus.fwd_data  = sel_data_c;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_wb_arbiter;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.WIDTH(W)) bus ();

    wb_arbiter #(.WIDTH(W), .DEPTH(D), .STARVE_LIM(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        live;
        bit [4:0]  rd;
        bit [31:0] data;
    } ent_t;

    int n_pass  = 0;
    int n_total = 0;

    ent_t      q[$];
    int        cnt;
    bit        sel_rst;
    bit        sel_we;
    bit [4:0]  sel_rd;
    bit [31:0] sel_wd;
    bit        exp_we;
    bit [4:0]  exp_ad;
    bit [31:0] exp_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model of one cycle: decides the write selected this cycle and the FIFO/counter after the edge.
    task automatic model(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                         input bit bv, input bit [4:0] brd, input bit [31:0] bd);
        bit   afire, bfire, popped;
        ent_t e;
        sel_we = 0; sel_rd = 0; sel_wd = 0;
        if (r) begin
            q.delete();
            cnt     = 0;
            sel_rst = 1;
            return;
        end
        sel_rst = 0;
        afire  = av && (cnt != LIM);
        bfire  = bv && (q.size() != D);
        popped = 0;
        if (afire && ard != 0) begin
            sel_we = 1; sel_rd = ard; sel_wd = ad;
            foreach (q[i]) begin
                if (q[i].rd == ard) begin
                    e = q[i]; e.live = 0; q[i] = e;
                end
            end
        end
        if (q.size() > 0) begin
            if (!q[0].live) begin
                void'(q.pop_front());
                popped = 1;
            end else if (!afire) begin
                sel_we = 1; sel_rd = q[0].rd; sel_wd = q[0].data;
                void'(q.pop_front());
                popped = 1;
            end
        end
        if (popped) cnt = 0;
        else if (q.size() > 0 && afire) cnt++;
        if (bfire && brd != 0) begin
            e.live = 1; e.rd = brd; e.data = bd;
            q.push_back(e);
        end
    endtask

    task automatic drive(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                         input bit bv, input bit [4:0] brd, input bit [31:0] bd);
        rst         = r;
        bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad;
        bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bd;
        model(r, av, ard, ad, bv, brd, bd);
`ifdef WB_BYPASS_EN
        #1;
        if (!r) begin
            chk("fwd_valid", 32'(bus.fwd_valid), 32'(sel_we));
            if (sel_we) begin
                chk("fwd_rd", 32'(bus.fwd_rd), 32'(sel_rd));
                chk("fwd_data", bus.fwd_data, sel_wd);
            end
        end
`endif
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
        if (sel_rst) begin
            exp_we = 0; exp_ad = 0; exp_wd = 0;
        end else begin
            exp_we = sel_we;
            if (sel_we) begin
                exp_ad = sel_rd; exp_wd = sel_wd;
            end
        end
        chk("WE3", 32'(bus.WE3), 32'(exp_we));
        if (exp_we || sel_rst) begin
            chk("AD3", 32'(bus.AD3), 32'(exp_ad));
            chk("WD3", bus.WD3, exp_wd);
        end
        chk("busy", 32'(bus.busy), 32'((q.size() > 0) || exp_we));
        chk("a_ready", 32'(bus.a_ready), 32'(cnt != LIM));
        chk("b_ready", 32'(bus.b_ready), 32'(q.size() != D));
    endtask

    task automatic step(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                        input bit bv, input bit [4:0] brd, input bit [31:0] bd);
        drive(r, av, ard, ad, bv, brd, bd);
        finish_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_WE3", 32'(bus.WE3), 32'd0);
        chk("rst_AD3", 32'(bus.AD3), 32'd0);
        chk("rst_WD3", bus.WD3, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_a_ready", 32'(bus.a_ready), 32'd1);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd1);

        // A only.
        step(0, 1, 5, 32'hDEAD, 0, 0, 0);
        chk("a_WE3", 32'(bus.WE3), 32'd1);
        chk("a_AD3", 32'(bus.AD3), 32'd5);
        chk("a_WD3", bus.WD3, 32'hDEAD);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("a_WE3_drop", 32'(bus.WE3), 32'd0);

        // B only: x0 discarded, then one real write.
        step(0, 0, 0, 0, 1, 0, 32'h5555);
        chk("b0_busy", 32'(bus.busy), 32'd0);
        step(0, 0, 0, 0, 1, 7, 32'h1234);
        chk("b7_busy", 32'(bus.busy), 32'd1);
        chk("b7_WE3_early", 32'(bus.WE3), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("b7_WE3", 32'(bus.WE3), 32'd1);
        chk("b7_AD3", 32'(bus.AD3), 32'd7);
        chk("b7_WD3", bus.WD3, 32'h1234);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("b7_busy_fall", 32'(bus.busy), 32'd0);

        // Fill FIFO while A streams, then the starvation throttle.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 32'(100 + i), 1, 5'(10 + i), 32'(200 + i));
        chk("fill_b_ready", 32'(bus.b_ready), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 32'(300 + i), 0, 0, 0);
        chk("starve_a_ready", 32'(bus.a_ready), 32'd0);
        step(0, 1, 1, 32'h777, 0, 0, 0);
        chk("starve_WE3", 32'(bus.WE3), 32'd1);
        chk("starve_AD3", 32'(bus.AD3), 32'd10);
        chk("starve_WD3", bus.WD3, 32'd200);
        chk("starve_a_ready_back", 32'(bus.a_ready), 32'd1);
        idle(6);
        chk("drain_busy", 32'(bus.busy), 32'd0);

        // Kill: younger A write to the same rd supersedes the queued B entry.
        step(0, 0, 0, 0, 1, 3, 32'h11);
        step(0, 1, 3, 32'h22, 0, 0, 0);
        chk("kill_WE3", 32'(bus.WE3), 32'd1);
        chk("kill_AD3", 32'(bus.AD3), 32'd3);
        chk("kill_WD3", bus.WD3, 32'h22);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("kill_no_write", 32'(bus.WE3), 32'd0);
        chk("kill_busy", 32'(bus.busy), 32'd0);

        // Mid-operation reset with 3 queued entries and a write in flight.
        for (int i = 0; i < 3; i++) step(0, 1, 2, 32'(400 + i), 1, 5'(20 + i), 32'(500 + i));
        chk("pre_rst_WE3", 32'(bus.WE3), 32'd1);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        step(1, 1, 2, 32'h999, 1, 25, 32'h888);
        chk("mid_rst_WE3", 32'(bus.WE3), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_b_ready", 32'(bus.b_ready), 32'd1);
        idle(5);

`ifdef WB_BYPASS_EN
        // Bypass view in the selection cycle.
        drive(0, 1, 9, 32'hCAFE, 0, 0, 0);
        chk("byp_fwd_valid", 32'(bus.fwd_valid), 32'd1);
        chk("byp_fwd_rd", 32'(bus.fwd_rd), 32'd9);
        chk("byp_fwd_data", bus.fwd_data, 32'hCAFE);
        finish_cycle();
        chk("byp_WE3", 32'(bus.WE3), 32'd1);
        chk("byp_AD3", 32'(bus.AD3), 32'd9);
`endif

        // Randomized traffic over a small rd range to provoke kills and x0 drops.
        for (int i = 0; i < 3000; i++) begin
            bit r, av, bv;
            r  = ($urandom_range(0, 299) == 0);
            av = ($urandom_range(0, 2) != 0);
            bv = ($urandom_range(0, 3) != 0);
            step(r, av, 5'($urandom_range(0, 4)), $urandom,
                 bv, 5'($urandom_range(0, 4)), $urandom);
        end
        idle(8);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
